// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants, state encoding and digit helper for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFin   = 2'd2
  } state_e;

  localparam logic [3:0] BcdDigitMax  = 4'd9;
  localparam logic [3:0] BcdAdj       = 4'd3;
  localparam logic [3:0] BcdAdjThresh = 4'd8;

  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > BcdDigitMax;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_digit_adj.sv
// Per-digit correction for reverse double-dabble: digits of 8 or more lose 3 after a right shift.
module bcd2bin_seq_digit_adj
  import bcd2bin_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BcdAdjThresh) begin
      digit_o = digit_i - BcdAdj;
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one bit per clock, DONE pulse on
// completion with sticky VALUE and per-conversion ERR for non-decimal digits.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int unsigned Digits = 2,
  parameter int unsigned BinW   = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [4*Digits-1:0]   bcd_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BinW-1:0]       value_o,
  output logic                  err_o
);

  localparam int unsigned SrW  = 4 * Digits;
  localparam int unsigned CntW = $clog2(SrW + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SrW - 1);

  state_e            state_q;
  logic [SrW-1:0]    bcd_sr_q;
  logic [SrW-1:0]    bin_sr_q;
  logic [CntW-1:0]   cnt_q;
  logic              err_flag_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [BinW-1:0]   value_q;

  logic [SrW-1:0]    bcd_shift;
  logic [SrW-1:0]    bcd_adj;
  logic [SrW-1:0]    bin_shift;
  logic [Digits-1:0] digit_bad;
  logic              in_err;

  assign bcd_shift = bcd_sr_q >> 1;
  assign bin_shift = {bcd_sr_q[0], bin_sr_q[SrW-1:1]};

  for (genvar i = 0; i < Digits; i++) begin : g_digit
    bcd2bin_seq_digit_adj u_adj (
      .digit_i (bcd_shift[4*i +: 4]),
      .digit_o (bcd_adj[4*i +: 4])
    );
    assign digit_bad[i] = digit_invalid(bcd_in_i[4*i +: 4]);
  end

  assign in_err = |digit_bad;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      bcd_sr_q   <= '0;
      bin_sr_q   <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      value_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StShift;
            if (in_err) begin
              err_flag_q <= 1'b1;
            end else begin
              err_flag_q <= 1'b0;
              bcd_sr_q   <= bcd_in_i;
              bin_sr_q   <= '0;
            end
          end
        end
        StShift: begin
          // Rejected codes pass through here once without touching the datapath,
          // so their DONE lands two cycles after START.
          if (err_flag_q) begin
            state_q <= StFin;
          end else begin
            bcd_sr_q <= bcd_adj;
            bin_sr_q <= bin_shift;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= StFin;
            end
          end
        end
        StFin: begin
          if (!err_flag_q) begin
            value_q <= bin_sr_q[BinW-1:0];
          end
          err_q   <= err_flag_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign value_o = value_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq against a decimal-arithmetic reference model.
module tb_bcd2bin_seq;

  localparam int Digits = 2;
  localparam int BinW   = 7;
  localparam int LatOk  = 4 * Digits + 1;
  localparam int LatErr = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       bcd = 8'h00;
  logic             busy;
  logic             done;
  logic             err;
  logic [BinW-1:0]  value;

  int checks = 0;
  int errors = 0;
  int last_value = 0;

  always #5 clk = ~clk;

  bcd2bin_seq #(
    .Digits (Digits),
    .BinW   (BinW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .bcd_in_i (bcd),
    .busy_o   (busy),
    .done_o   (done),
    .value_o  (value),
    .err_o    (err)
  );

  function automatic int ref_value(input logic [7:0] b);
    int v = 0;
    for (int i = Digits - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit ref_valid(input logic [7:0] b);
    for (int i = 0; i < Digits; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Drives one START and waits (bounded) for DONE; called just after a rising edge.
  task automatic run_conv(input logic [7:0] code, output int lat, output int busy_cyc,
                          output logic [BinW-1:0] val, output logic e);
    bcd = code;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_cyc = busy ? 1 : 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_cyc++;
    end
    val = value;
    e = err;
  endtask

  task automatic test_reset();
    int n_done;
    int lat, bc;
    logic [BinW-1:0] v;
    logic e;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b expected 0", done); end
    checks++; if (value !== '0) begin errors++; $display("FAIL reset_value got %0d expected 0", value); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b expected 0", err); end
    rst = 1'b0;
    @(posedge clk); #1;
    bcd = 8'h57;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b expected 0", busy); end
    checks++; if (value !== '0) begin errors++; $display("FAIL midreset_value got %0d expected 0", value); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_value = 0;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL midreset_nodone got %0d expected 0", n_done); end
    run_conv(8'h57, lat, bc, v, e);
    checks++; if (lat != LatOk) begin errors++; $display("FAIL after_reset_lat got %0d expected %0d", lat, LatOk); end
    checks++; if (v !== 7'd57) begin errors++; $display("FAIL after_reset_value got %0d expected 57", v); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL after_reset_err got %0b expected 0", e); end
    last_value = 57;
  endtask

  task automatic test_sweep();
    int lat, bc, exp_v;
    logic [BinW-1:0] v;
    logic e;
    logic [7:0] code;
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        code = {4'(t), 4'(o)};
        exp_v = t * 10 + o;
        run_conv(code, lat, bc, v, e);
        checks++; if (lat != LatOk) begin errors++; $display("FAIL sweep_lat code=%h got %0d expected %0d", code, lat, LatOk); end
        checks++; if (int'(v) != exp_v) begin errors++; $display("FAIL sweep_value code=%h got %0d expected %0d", code, v, exp_v); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sweep_err code=%h got %0b expected 0", code, e); end
        last_value = exp_v;
      end
    end
  endtask

  task automatic test_invalid();
    int lat, bc;
    logic [BinW-1:0] v;
    logic e;
    logic [7:0] codes [3];
    codes[0] = 8'h1A;
    codes[1] = 8'hF3;
    codes[2] = 8'h05;
    run_conv(8'h42, lat, bc, v, e);
    checks++; if (v !== 7'd42) begin errors++; $display("FAIL inv_pre_value got %0d expected 42", v); end
    last_value = 42;
    for (int i = 0; i < 3; i++) begin
      run_conv(codes[i], lat, bc, v, e);
      if (ref_valid(codes[i])) last_value = ref_value(codes[i]);
      checks++; if (lat != (ref_valid(codes[i]) ? LatOk : LatErr)) begin
        errors++; $display("FAIL inv_lat code=%h got %0d", codes[i], lat);
      end
      checks++; if (int'(v) != last_value) begin
        errors++; $display("FAIL inv_value code=%h got %0d expected %0d", codes[i], v, last_value);
      end
      checks++; if (e !== !ref_valid(codes[i])) begin
        errors++; $display("FAIL inv_err code=%h got %0b expected %0b", codes[i], e, !ref_valid(codes[i]));
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n_done = 0;
    int first_c = -1;
    logic [BinW-1:0] v = '0;
    bcd = 8'h25;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        bcd = 8'h88;
        start = 1'b1;
      end
      if (c == 4) start = 1'b0;
      if (done) begin
        n_done++;
        if (first_c < 0) begin
          first_c = c;
          v = value;
        end
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL busy_ndone got %0d expected 1", n_done); end
    checks++; if (first_c != LatOk) begin errors++; $display("FAIL busy_lat got %0d expected %0d", first_c, LatOk); end
    checks++; if (v !== 7'd25) begin errors++; $display("FAIL busy_value got %0d expected 25", v); end
    last_value = 25;
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, idle_gaps = 0;
    logic [BinW-1:0] v1 = '0, v2 = '0;
    bcd = 8'h31;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!busy && !done) idle_gaps++;
      if (done) begin
        if (d1 < 0) begin
          d1 = c; v1 = value; bcd = 8'h64;
        end else begin
          d2 = c; v2 = value; start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++; if (d1 != LatOk) begin errors++; $display("FAIL b2b_d1 got %0d expected %0d", d1, LatOk); end
    checks++; if (d2 != 2 * LatOk + 1) begin errors++; $display("FAIL b2b_d2 got %0d expected %0d", d2, 2 * LatOk + 1); end
    checks++; if (v1 !== 7'd31) begin errors++; $display("FAIL b2b_v1 got %0d expected 31", v1); end
    checks++; if (v2 !== 7'd64) begin errors++; $display("FAIL b2b_v2 got %0d expected 64", v2); end
    checks++; if (idle_gaps != 0) begin errors++; $display("FAIL b2b_gaps got %0d expected 0", idle_gaps); end
    last_value = 64;
  endtask

  task automatic test_boundary();
    int lat, bc;
    logic [BinW-1:0] v;
    logic e;
    logic [7:0] codes [3];
    codes[0] = 8'h00;
    codes[1] = 8'h09;
    codes[2] = 8'h90;
    for (int i = 0; i < 3; i++) begin
      run_conv(codes[i], lat, bc, v, e);
      checks++; if (int'(v) != ref_value(codes[i])) begin
        errors++; $display("FAIL bound_value code=%h got %0d expected %0d", codes[i], v, ref_value(codes[i]));
      end
      checks++; if (bc != LatOk) begin errors++; $display("FAIL bound_busy code=%h got %0d expected %0d", codes[i], bc, LatOk); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL bound_err code=%h got %0b expected 0", codes[i], e); end
      last_value = ref_value(codes[i]);
    end
  endtask

  task automatic test_random();
    int lat, bc, exp_lat;
    logic [BinW-1:0] v;
    logic e;
    logic [7:0] code;
    for (int i = 0; i < 40; i++) begin
      code = 8'($urandom_range(0, 255));
      exp_lat = ref_valid(code) ? LatOk : LatErr;
      if (ref_valid(code)) last_value = ref_value(code);
      run_conv(code, lat, bc, v, e);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_lat code=%h got %0d expected %0d", code, lat, exp_lat); end
      checks++; if (int'(v) != last_value) begin errors++; $display("FAIL rand_value code=%h got %0d expected %0d", code, v, last_value); end
      checks++; if (e !== !ref_valid(code)) begin errors++; $display("FAIL rand_err code=%h got %0b expected %0b", code, e, !ref_valid(code)); end
      checks++; if (bc != exp_lat) begin errors++; $display("FAIL rand_busy code=%h got %0d expected %0d", code, bc, exp_lat); end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_invalid();
    test_busy_ignore();
    test_back_to_back();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
